// File: rtl/arb_req_queue.sv
// ============================================================================
// Module   : arb_req_queue
// Purpose  : Per-channel request FIFOs feeding a round-robin arbiter, with a
//            registered valid/ready output stage loaded by the one-hot grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_req_queue #(
    parameter int WIDTH  = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_valid,
    output logic [WIDTH-1:0]         in_ready,
    input  logic [WIDTH*DATA_W-1:0]  in_data,
    output logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         grt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [WIDTH-1:0]         out_src,
    output logic                     grt_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic                           r_out_valid;
    logic [DATA_W-1:0]              r_out_data;
    logic [WIDTH-1:0]               r_out_src;
    logic                           r_grt_err;

    logic                           w_slot_free;
    logic [WIDTH-1:0]               w_nonempty;
    logic [WIDTH-1:0]               w_pop;
    logic                           w_onehot;
    logic                           w_legal;
    logic                           w_illegal;
    logic [WIDTH-1:0][DATA_W-1:0]   w_head_ch;
    logic [DATA_W-1:0]              w_head;

    assign w_slot_free = !r_out_valid | out_ready;
    assign req         = w_nonempty & {WIDTH{w_slot_free}};

    assign w_onehot  = (grt != '0) && ((grt & (grt - WIDTH'(1))) == '0);
    assign w_legal   = w_onehot && ((grt & req) == grt);
    assign w_illegal = (grt != '0) && !w_legal;
    assign w_pop     = grt & {WIDTH{w_legal}};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wptr;
            logic [PTR_W-1:0]  r_rptr;
            logic [CNT_W-1:0]  r_count;
            logic              w_push;

            // Space is judged on the registered count only: a full channel
            // refuses a push even while it is being popped.
            assign in_ready[i]   = (r_count < C_DEPTH);
            assign w_push        = in_valid[i] & in_ready[i];
            assign w_nonempty[i] = (r_count != '0);
            assign w_head_ch[i]  = r_mem[r_rptr];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push)
                        r_wptr <= r_wptr + PTR_W'(1);
                    if (w_pop[i])
                        r_rptr <= r_rptr + PTR_W'(1);
                    case ({w_push, w_pop[i]})
                        2'b10:   r_count <= r_count + CNT_W'(1);
                        2'b01:   r_count <= r_count - CNT_W'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wptr] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    endgenerate

    always_comb begin
        w_head = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grt[i])
                w_head = w_head | w_head_ch[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_grt_err   <= 1'b0;
        end else begin
            if (w_legal) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head;
                r_out_src   <= grt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_illegal)
                r_grt_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign grt_err   = r_grt_err;

endmodule

`default_nettype wire

// File: tb/tb_arb_req_queue.sv
// ============================================================================
// Module   : tb_arb_req_queue
// Purpose  : Directed scoreboard bench for arb_req_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arb_req_queue;

    localparam int WIDTH  = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic                    clk;
    logic                    rst;
    logic [WIDTH-1:0]        in_valid;
    logic [WIDTH-1:0]        in_ready;
    logic [WIDTH*DATA_W-1:0] in_data;
    logic [WIDTH-1:0]        req;
    logic [WIDTH-1:0]        grt;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [WIDTH-1:0]        out_src;
    logic                    grt_err;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W+WIDTH-1:0] exp_q [$];

    arb_req_queue #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .grt       (grt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grt_err   (grt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a transfer completes on the next rising edge whenever
    // valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data=0x%0h src=0x%0h expected none",
                         out_data, out_src);
            end else begin
                logic [DATA_W+WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("sb_data", 64'(out_data), 64'(e[DATA_W+WIDTH-1:WIDTH]));
                check("sb_src",  64'(out_src),  64'(e[WIDTH-1:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d);
        in_valid = WIDTH'(1) << ch;
        in_data[ch*DATA_W +: DATA_W] = d;
        cyc();
        in_valid = '0;
    endtask

    task automatic grant(input int ch, input logic [DATA_W-1:0] exp_d);
        grt = WIDTH'(1) << ch;
        exp_q.push_back({exp_d, WIDTH'(1) << ch});
        cyc();
        grt = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] g;
        int p;
        rst       = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        grt       = '0;
        out_ready = 1'b0;
        #13;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_req",       64'(req),       64'h00);
        check("rst_in_ready",  64'(in_ready),  64'hFF);
        check("rst_grt_err",   64'(grt_err),   64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_out_src",   64'(out_src),   64'h0);
        rst = 1'b1;
        cyc();

        // Single entry on ch0
        out_ready = 1'b1;
        push(0, 32'hA5);
        check("single_req", 64'(req), 64'h01);
        grant(0, 32'hA5);
        check("single_valid", 64'(out_valid), 64'h1);
        check("single_data",  64'(out_data),  64'hA5);
        check("single_src",   64'(out_src),   64'h01);
        cyc();
        check("single_drain", 64'(out_valid), 64'h0);

        // Full channel: third push is refused
        push(3, 32'h11);
        push(3, 32'h22);
        check("full_in_ready", 64'(in_ready), 64'hF7);
        push(3, 32'h33);
        check("full_req", 64'(req), 64'h08);
        grant(3, 32'h11);
        check("full_data1", 64'(out_data), 64'h11);
        check("full_ready_back", 64'(in_ready), 64'hFF);
        grant(3, 32'h22);
        check("full_data2", 64'(out_data), 64'h22);
        cyc();
        check("full_empty_req", 64'(req), 64'h00);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 8'h26;
        in_data[1*DATA_W +: DATA_W] = 32'h101;
        in_data[2*DATA_W +: DATA_W] = 32'h202;
        in_data[5*DATA_W +: DATA_W] = 32'h505;
        cyc();
        in_valid = '0;
        check("bp_req_open", 64'(req), 64'h26);
        grant(1, 32'h101);
        for (int k = 0; k < 5; k++) begin
            check("bp_req_zero", 64'(req),       64'h00);
            check("bp_valid",    64'(out_valid), 64'h1);
            check("bp_data",     64'(out_data),  64'h101);
            check("bp_src",      64'(out_src),   64'h02);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_req_resume", 64'(req), 64'h24);
        grant(2, 32'h202);
        check("bp_stream_valid", 64'(out_valid), 64'h1);
        check("bp_stream_data",  64'(out_data),  64'h202);
        grant(5, 32'h505);
        check("bp_stream_data2", 64'(out_data),  64'h505);
        cyc();
        check("bp_drain", 64'(out_valid), 64'h0);

        // Illegal grant
        push(1, 32'h77);
        check("ill_req", 64'(req), 64'h02);
        grt = 8'h06;
        cyc();
        grt = '0;
        check("ill_err",      64'(grt_err),  64'h1);
        check("ill_valid",    64'(out_valid), 64'h0);
        check("ill_data",     64'(out_data), 64'h505);
        check("ill_src",      64'(out_src),  64'h20);
        check("ill_no_pop",   64'(req),      64'h02);
        repeat (10) cyc();
        check("ill_sticky", 64'(grt_err), 64'h1);
        grant(1, 32'h77);
        cyc();

        // All eight channels drained by a round-robin grant model
        in_valid = 8'hFF;
        for (int i = 0; i < WIDTH; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'(i);
        cyc();
        in_valid = '0;
        p = 0;
        for (int k = 0; k < WIDTH; k++) begin
            g = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (g == '0 && req[(p + j) % WIDTH]) g = WIDTH'(1) << ((p + j) % WIDTH);
            end
            check("rr_grant", 64'(g), 64'(WIDTH'(1) << k));
            p = k + 1;
            grant(k, DATA_W'(k));
            check("rr_valid", 64'(out_valid), 64'h1);
        end
        cyc();
        check("rr_drain", 64'(out_valid), 64'h0);

        // Reset mid-stream with channels still loaded
        out_ready = 1'b0;
        in_valid = 8'h51;
        in_data[0*DATA_W +: DATA_W] = 32'hC0;
        in_data[4*DATA_W +: DATA_W] = 32'hC4;
        in_data[6*DATA_W +: DATA_W] = 32'hC6;
        cyc();
        in_data[0*DATA_W +: DATA_W] = 32'hC1;
        in_valid = 8'h01;
        cyc();
        in_valid = '0;
        grt = 8'h01;
        cyc();
        grt = '0;
        check("mid_loaded", 64'(out_valid), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid",    64'(out_valid), 64'h0);
        check("mid_rst_req",      64'(req),       64'h00);
        check("mid_rst_in_ready", 64'(in_ready),  64'hFF);
        check("mid_rst_err",      64'(grt_err),   64'h0);
        cyc();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_rst_req",   64'(req),       64'h00);
            check("post_rst_valid", 64'(out_valid), 64'h0);
        end
        push(2, 32'hF2);
        grant(2, 32'hF2);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) cyc();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arb_req_queue.md
# arb_req_queue

Requester-side companion to the round-robin arbiter. It buffers up to DEPTH entries per source channel and drives a `req` vector into the arbiter. It accepts the arbiter's one-hot `grt` in the same cycle, pops the granted entry, and registers it onto a single valid/ready output. It also suppresses all requests whenever the output stage cannot take a grant, so a granted requester always uses its grant within the clock.

## Interface
Parameters:
- WIDTH, 8: number of source channels; must match the arbiter WIDTH.
- DATA_W, 32: payload width per entry.
- DEPTH, 2: entries per channel FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  WIDTH  per-channel push strobe.
- in_ready  out  WIDTH  per-channel space available; `in_ready[i]` = (count[i] < DEPTH).
- in_data  in  WIDTH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- req  out  WIDTH  request vector to the arbiter; combinational.
- grt  in  WIDTH  one-hot grant from the arbiter, same cycle as `req`.
- out_valid  out  1  output entry valid; registered.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  granted payload; registered.
- out_src  out  WIDTH  one-hot source channel of `out_data`; registered.
- grt_err  out  1  sticky flag for an illegal grant.

## Operation
- **Per-channel FIFO.** Each channel has a DEPTH-entry circular FIFO with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH. It has a count register of log2(DEPTH)+1 bits.
- **Push.** A push on channel i occurs when `in_valid[i] & in_ready[i]`. `in_ready` comes from registered count only, so a full channel refuses a push even when it pops in the same cycle.
- **Output slot.** `slot_free` = !out_valid | out_ready.
- **Request generation.** `req[i]` = (count[i] != 0) & slot_free. When `slot_free` = 0, `req` = 0 for every channel.
- **Legal grant.** A grant is legal when `grt` is one-hot and `(grt & req) == grt`.
- **Legal grant in a cycle:**
  - The granted channel's head entry is popped.
  - On the edge: out_data ← head, out_src ← grt, out_valid ← 1.
- **No legal grant in a cycle:**
  - If `out_ready` = 1, out_valid ← 0.
  - Otherwise out_valid, out_data and out_src hold.
- **Illegal grant.** An illegal grant is nonzero `grt` that is not one-hot, or that grants a channel with `req` = 0.
  - No channel is popped and the output register is unchanged.
  - grt_err ← 1, and it stays 1 until reset.
- **Output stability.** While `out_valid` = 1 and `out_ready` = 0, out_data and out_src are held stable.
- **Same-channel push and pop.** A push and a pop on the same channel in one cycle is allowed when the channel is not full; count is unchanged.
- **Different-channel events.** Pushes and pops on different channels in the same cycle are independent.
- **Ordering.** Entries leave each channel in FIFO order. Cross-channel ordering is the arbiter's round-robin order.
- **Reset values:**
  - FIFOs empty: counts 0, pointers 0.
  - out_valid = 0, out_data = 0, out_src = 0, grt_err = 0.
  - Consequently req = 0 and in_ready = all ones.
- **Reset mid-operation.** An asynchronous reset mid-operation discards all buffered and output entries immediately.

## Timing
- **Push to request.** A push accepted at edge t makes `req[i]` = 1 during the cycle after edge t; no same-cycle bypass.
- **Grant to output.** A grant in the cycle after edge t gives `out_valid` = 1 after edge t+1.
- **End-to-end latency.** Minimum input-to-output latency is 2 edges.
- **Throughput.** One entry per cycle with `out_ready` held at 1, back-to-back across any channels.
- **Space reporting.** `in_ready[i]` rises the cycle after the pop that frees space.
- **Combinational paths.**
  - `req` depends combinationally on out_valid, out_ready and counts.
  - The pop and output-register load depend combinationally on `grt`.
  - There are no other combinational input-to-output paths.

## Test plan
- **Single entry.** After reset, push 0xA5 on ch0 → next cycle req=0x01. With grt=0x01: out_valid=1, out_data=0xA5, out_src=0x01 one edge later. With out_ready=1, out_valid=0 afterwards.
- **Full channel.** Push 0x11 and 0x22 on ch3 (DEPTH=2) → in_ready[3]=0 and a third push of 0x33 is ignored. Grant ch3 → out_data=0x11; in_ready[3]=1 next cycle. Next grant → 0x22; 0x33 never appears.
- **Backpressure.** With out_valid=1 and out_ready=0 for 5 cycles → req=0x00 and out_data/out_src stable. Raise out_ready → entries stream back-to-back, one per cycle.
- **Illegal grant.** Force grt=0x06 while req=0x02 → no pop, output unchanged, grt_err=1. grt_err is still 1 after 10 further cycles and clears only on rst=0.
- **With the real arbiter.** Connect to the round-robin arbiter, load one entry on each of the 8 channels with data=channel index, out_ready=1 → out_src 0x01,0x02,…,0x80 in consecutive cycles, out_data 0..7.
- **Reset mid-stream.** Assert rst low mid-stream with 3 channels non-empty → asynchronously out_valid=0, req=0x00, in_ready=0xFF. After release, no stale entry is ever output.
